// File: rtl/recon_iter_ctrl.sv
// recon_iter_ctrl: sequences fill and iterative replay passes of the limits buffer.
// Optional macro ITER_CTRL_BACKPRESSURE_EN adds out_ready so replay beats stall on the limiter.
module recon_iter_ctrl #(
    parameter int MAX_SAMPLES = 255,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] num_samples,
    input  logic [7:0] num_iters,
    input  logic       lvl_gen_valid,
`ifdef ITER_CTRL_BACKPRESSURE_EN
    input  logic       out_ready,
`endif
    output logic       iter_input_enable,
    output logic       iter_output_enable,
    output logic [7:0] iter_index,
    output logic       iter_last,
    output logic       busy,
    output logic       done
);
    localparam logic [7:0] MAX8 = 8'(MAX_SAMPLES);
    localparam logic [7:0] GAP8 = 8'(GAP_CYCLES);
    typedef enum logic [2:0] {IDLE, FILL, GAP, ITER, DONE} state_t;
    state_t     state_q, state_d;
    logic [7:0] ns_q, ns_d, ni_q, ni_d;
    logic [7:0] fill_cnt_q, fill_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d, iter_idx_q, iter_idx_d;
    logic [7:0] ns_clamped;
    logic       ready;
`ifdef ITER_CTRL_BACKPRESSURE_EN
    assign ready = out_ready;
`else
    assign ready = 1'b1;
`endif
    assign ns_clamped = (num_samples > MAX8) ? MAX8 : num_samples;
    always_comb begin
        state_d    = state_q;
        ns_d       = ns_q;
        ni_d       = ni_q;
        fill_cnt_d = fill_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        iter_idx_d = iter_idx_q;
        case (state_q)
            IDLE: if (start) begin
                ns_d    = ns_clamped;
                ni_d    = num_iters;
                state_d = (ns_clamped == 8'd0 || num_iters == 8'd0) ? DONE : FILL;
            end
            FILL: if (lvl_gen_valid) begin
                fill_cnt_d = fill_cnt_q + 8'd1;
                if (fill_cnt_q == ns_q - 8'd1) begin
                    fill_cnt_d = 8'd0;
                    state_d    = (GAP_CYCLES == 0) ? ITER : GAP;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 8'd1;
                if (gap_cnt_q == GAP8 - 8'd1) begin
                    gap_cnt_d = 8'd0;
                    state_d   = (iter_idx_q == ni_q) ? DONE : ITER;
                end
            end
            ITER: if (ready) begin
                rd_cnt_d = rd_cnt_q + 8'd1;
                if (rd_cnt_q == ns_q - 8'd1) begin
                    rd_cnt_d   = 8'd0;
                    iter_idx_d = iter_idx_q + 8'd1;
                    // Without a gap the pass-count test moves here from GAP
                    state_d    = (GAP_CYCLES != 0) ? GAP :
                                 (iter_idx_q + 8'd1 == ni_q) ? DONE : ITER;
                end
            end
            DONE: begin
                iter_idx_d = 8'd0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            fill_cnt_d = 8'd0;
            rd_cnt_d   = 8'd0;
            gap_cnt_d  = 8'd0;
            iter_idx_d = 8'd0;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ns_q       <= 8'd0;
            ni_q       <= 8'd0;
            fill_cnt_q <= 8'd0;
            rd_cnt_q   <= 8'd0;
            gap_cnt_q  <= 8'd0;
            iter_idx_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            ns_q       <= ns_d;
            ni_q       <= ni_d;
            fill_cnt_q <= fill_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            iter_idx_q <= iter_idx_d;
        end
    end
    assign iter_input_enable  = state_q == FILL;
    assign iter_output_enable = state_q == ITER && ready;
    assign iter_index         = iter_idx_q;
    assign iter_last          = state_q == ITER && iter_idx_q == ni_q - 8'd1;
    assign busy               = state_q != IDLE;
    assign done               = state_q == DONE;
endmodule
